// File: rtl/guitar_hero_pkg.sv
// Shared definitions for the guitar-hero scoring path: FSM encoding, streak
// multiplier thresholds and saturation limits.
package guitar_hero_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_SCORE = 2'd2;
    localparam logic [1:0] ST_LOCK  = 2'd3;

    localparam logic [7:0]  MULT_T1    = 8'd10;
    localparam logic [7:0]  MULT_T2    = 8'd20;
    localparam logic [7:0]  MULT_T3    = 8'd30;
    localparam logic [7:0]  STREAK_MAX = 8'd255;
    localparam logic [31:0] SCORE_MAX  = 32'hFFFF_FFFF;

    // Multiplier applied to a hit, given the streak including that hit.
    function automatic logic [2:0] streak_mult(input logic [7:0] s);
        if (s < MULT_T1)      return 3'd1;
        else if (s < MULT_T2) return 3'd2;
        else if (s < MULT_T3) return 3'd3;
        else                  return 3'd4;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input, plus a one-cycle pulse on
// each synchronized 0->1 transition.
module sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic sync,
    output logic rise
);

    logic meta;
    logic q;
    logic q_d;

    // NOTE: sequential state uses non-blocking assignments so all three flops
    // sample the values from before the edge, forming a true shift chain.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
            q_d  <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
            q_d  <= q;
        end
    end

    assign sync = q;
    assign rise = q & ~q_d;

endmodule

// File: rtl/strum_judge.sv
// Scoring sequencer: debounces the strum, opens a gameclk-timed hit window,
// judges fret buttons against the note lanes and keeps score and streak.
module strum_judge
    import guitar_hero_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter int          WINDOW_TICKS    = 2,
    parameter logic [31:0] BASE_POINTS     = 32'd10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        gameclk,
    input  logic        strum,
    input  logic [3:0]  buttons,
    input  logic [3:0]  intersections,
    output logic [31:0] score,
    output logic [7:0]  streak,
    output logic        hit_pulse,
    output logic        miss_pulse
);

    localparam logic [19:0] DEB_LAST = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]  WIN_LAST = 4'(WINDOW_TICKS);

    logic       tick;
    logic       strum_sync;
    logic [3:0] buttons_sync;
    logic [5:0] unused_rise;

    sync_edge u_gameclk (.clock(clock), .reset(reset), .d(gameclk), .sync(unused_rise[5]), .rise(tick));
    sync_edge u_strum   (.clock(clock), .reset(reset), .d(strum),   .sync(strum_sync),     .rise(unused_rise[4]));

    for (genvar i = 0; i < 4; i++) begin : g_btn
        sync_edge u_btn (.clock(clock), .reset(reset), .d(buttons[i]), .sync(buttons_sync[i]), .rise(unused_rise[i]));
    end

    logic [1:0]  state;
    logic [19:0] deb_cnt;
    logic [3:0]  tick_cnt;
    logic        judged_hit;

    logic        match;
    logic        deb_done;
    logic [7:0]  streak_new;
    logic [34:0] score_sum;
    logic [31:0] score_new;

    assign match    = (intersections != 4'd0) && (buttons_sync == intersections);
    assign deb_done = (deb_cnt == DEB_LAST);

    // NOTE: every combinational output is assigned on every path, so no latch
    // can be inferred.
    always_comb begin
        streak_new = (streak == STREAK_MAX) ? streak : streak + 8'd1;
        score_sum  = 35'(score) + 35'(BASE_POINTS) * 35'(streak_mult(streak_new));
        score_new  = (score_sum > 35'(SCORE_MAX)) ? SCORE_MAX : score_sum[31:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            deb_cnt    <= 20'd0;
            tick_cnt   <= 4'd0;
            judged_hit <= 1'b0;
            score      <= 32'd0;
            streak     <= 8'd0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            if (!enable) begin
                state    <= ST_IDLE;
                deb_cnt  <= 20'd0;
                tick_cnt <= 4'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!strum_sync) begin
                            deb_cnt <= 20'd0;
                        end else if (deb_done) begin
                            deb_cnt  <= 20'd0;
                            tick_cnt <= 4'd0;
                            if (match) begin
                                judged_hit <= 1'b1;
                                state      <= ST_SCORE;
                            end else begin
                                state <= ST_ARMED;
                            end
                        end else begin
                            deb_cnt <= deb_cnt + 20'd1;
                        end
                    end
                    ST_ARMED: begin
                        // A match beats a window expiry landing on the same cycle.
                        if (match) begin
                            judged_hit <= 1'b1;
                            state      <= ST_SCORE;
                        end else if (tick) begin
                            if (tick_cnt + 4'd1 == WIN_LAST) begin
                                judged_hit <= 1'b0;
                                state      <= ST_SCORE;
                            end else begin
                                tick_cnt <= tick_cnt + 4'd1;
                            end
                        end
                    end
                    ST_SCORE: begin
                        tick_cnt <= 4'd0;
                        deb_cnt  <= 20'd0;
                        state    <= ST_LOCK;
                        if (judged_hit) begin
                            streak    <= streak_new;
                            score     <= score_new;
                            hit_pulse <= 1'b1;
                        end else begin
                            streak     <= 8'd0;
                            miss_pulse <= 1'b1;
                        end
                    end
                    default: begin
                        // LOCK: wait for a debounced release so a held strum scores once.
                        if (strum_sync) begin
                            deb_cnt <= 20'd0;
                        end else if (deb_done) begin
                            deb_cnt <= 20'd0;
                            state   <= ST_IDLE;
                        end else begin
                            deb_cnt <= deb_cnt + 20'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/strum_judge.md
# strum_judge

Sequences the guitar-hero scoring path: conditions the raw strum, gameclk and button inputs, opens a timed hit window on each accepted strum, judges buttons against the intersection lanes, and maintains score and streak with a streak multiplier. It sits beside the processor at the top level and drives the score bus, replacing ad-hoc scoring in software.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable cycles needed to accept a strum press or release (20-bit counter; board builds set about 100000).
- WINDOW_TICKS, 2: gameclk rising edges allowed after a strum before it is judged a miss (1..15).
- BASE_POINTS, 10: points per hit before multiplier (32-bit).
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- enable  in  1  game running; low holds FSM in IDLE and freezes score/streak.
- gameclk  in  1  asynchronous game tick, rising edge significant.
- strum  in  1  asynchronous strum bar, active-high.
- buttons  in  4  asynchronous fret buttons, one per lane.
- intersections  in  4  lanes with a note on the strike line, synchronous to clock.
- score  out  32  accumulated score.
- streak  out  8  consecutive hits.
- hit_pulse  out  1  one-cycle pulse per judged hit.
- miss_pulse  out  1  one-cycle pulse per judged miss.

## Operation
- Inputs strum, gameclk, buttons pass through 2-flop synchronizers; tick is a one-cycle pulse on synchronized gameclk 0->1.
- match = (intersections != 0) && (buttons_sync == intersections).
- strum_evt: synchronized strum high for DEBOUNCE_CYCLES consecutive cycles while in IDLE; a low cycle restarts the count.
- IDLE: strum_evt and match -> SCORE(hit); strum_evt without match -> ARMED, tick_cnt=0.
- ARMED: match -> SCORE(hit); else each tick increments tick_cnt; tick_cnt reaching WINDOW_TICKS -> SCORE(miss). Match and expiry in the same cycle: hit wins.
- SCORE (one cycle): hit: streak_new = min(streak+1, 255); mult = 1 if streak_new<10, 2 if <20, 3 if <30, else 4; score += BASE_POINTS*mult, saturating at 32'hFFFF_FFFF. Miss: streak=0, score unchanged. -> LOCK.
- LOCK: synchronized strum low for DEBOUNCE_CYCLES consecutive cycles -> IDLE. Strum activity in LOCK is never scored, so a held strum scores exactly once.
- enable low: next state IDLE from any state, no pulses; counters cleared; score/streak held.
- Reset mid-operation: FSM to IDLE, score=0, streak=0, pulses 0, all counters 0, synchronizer flops 0.

## Timing
- Reset values: score 0, streak 0, hit_pulse 0, miss_pulse 0.
- All outputs are registered; score, streak and pulse update on the edge that leaves SCORE; the pulse is high for exactly the following cycle.
- Strum rising at pin -> earliest hit_pulse: 2 (sync) + DEBOUNCE_CYCLES + 1 (IDLE->SCORE) + 1 cycles.
- Button latency: buttons_sync lags the pin by 2 cycles; intersections is used unsynchronized.
- Minimum strum-to-strum spacing: 2*DEBOUNCE_CYCLES + 2 cycles.

## Structure
- Shared package guitar_hero_pkg: FSM state encoding (IDLE, ARMED, SCORE, LOCK), multiplier thresholds (10/20/30), STREAK_MAX=255, SCORE_MAX.
- One sub-module, sync_edge: 2-flop synchronizer with optional rising-edge pulse output; instantiated for gameclk, strum and each button bit.
- The top level holds the FSM, debounce counter, tick counter and score arithmetic.

## Test plan
- Reset: assert reset 3 cycles mid-ARMED with score=50 -> score=0, streak=0, no pulse, FSM IDLE.
- Immediate hit: intersections=4'b0101, buttons=4'b0101, strum high 20 cycles -> exactly one hit_pulse, score=10, streak=1.
- Late hit: intersections=0 at strum, after 1 tick set intersections=buttons=4'b0010 -> hit_pulse, score +10; same-cycle expiry and match -> hit.
- Window miss: strum with no match for 2 ticks -> miss_pulse on the cycle after the 2nd tick is registered, streak=0, score unchanged.
- Multiplier: 10 consecutive hits from 0 -> score 110 (10th adds 20), streak=10; then a miss -> streak 0, score 110.
- Debounce/enable: strum high 3 cycles then low -> no event; strum with enable=0 -> no pulse, score held.
